// File: rtl/cla_multiword_seq.sv
// Multi-cycle wide adder/subtractor: feeds one N-bit slice per cycle through a
// carry-lookahead stage, registering the slice carry-out into the next slice.
module cla_multiword_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N*WORDS-1:0]   a_i,
    input  logic [N*WORDS-1:0]   b_i,
    input  logic                 cin_i,
    input  logic                 sub_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [N*WORDS-1:0]   sum_o,
    output logic                 cout_o,
    output logic                 busy_o
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    opA_q, opA_d;
    logic [W-1:0]    opB_q, opB_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            outValid_q, outValid_d;

    int              sliceBase;
    logic [N-1:0]    sliceA, sliceB, sliceG, sliceP, sliceSum;
    logic [N:0]      sliceC;
    logic            sliceCout;

    // Carry-lookahead stage over the slice selected by idx, seeded by the registered carry.
    always_comb begin
        sliceBase = N * int'(idx_q);
        sliceA    = opA_q[sliceBase +: N];
        sliceB    = opB_q[sliceBase +: N];
        sliceG    = sliceA & sliceB;
        sliceP    = sliceA ^ sliceB;
        sliceC    = '0;
        sliceC[0] = carry_q;
        for (int i = 0; i < N; i++) begin
            sliceC[i+1] = sliceG[i] | (sliceP[i] & sliceC[i]);
        end
        sliceSum  = sliceP ^ sliceC[N-1:0];
        sliceCout = sliceC[N];
    end

    // Next-state logic: capture in IDLE, one slice per ADD cycle, hold result in DONE.
    always_comb begin
        state_d    = state_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        outValid_d = outValid_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    opA_d   = a_i;
                    opB_d   = sub_i ? ~b_i : b_i;
                    carry_d = sub_i ? 1'b1 : cin_i;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[sliceBase +: N] = sliceSum;
                carry_d               = sliceCout;
                if (idx_q == IW'(WORDS - 1)) begin
                    cout_d     = sliceCout;
                    outValid_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset aborts any operation in flight and zeroes the visible result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
            outValid_q <= outValid_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE) && !rst;
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = outValid_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Self-checking bench for cla_multiword_seq: directed corner cases plus randomized
// traffic compared every cycle against an arithmetic model of the adder.
module tb_cla_multiword_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    cla_multiword_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wide result straight from unsigned arithmetic: subtract reports "no borrow" as cout.
    function automatic logic [W:0] refResult(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
        if (s) return {(x >= y), x - y};
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    // Cycle-level model: phase 0 idle, 1 adding (mCnt slices done), 2 result held.
    int            mPhase   = 0;
    int            mCnt     = 0;
    int            mAccepts = 0;
    logic [W-1:0]  pendSum  = '0;
    logic          pendCout = 1'b0;
    logic [W-1:0]  mSum     = '0;
    logic          mCout    = 1'b0;
    logic          mValid   = 1'b0;
    logic          checkEn  = 1'b0;
    logic [W-1:0]  expSum;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase = 0; mCnt = 0; mSum = '0; mCout = 1'b0; mValid = 1'b0;
        end else begin
            case (mPhase)
                0: if (in_valid) begin
                    {pendCout, pendSum} = refResult(a, b, cin, sub);
                    mCnt = 0; mPhase = 1; mAccepts++;
                end
                1: begin
                    mCnt++;
                    if (mCnt == WORDS) begin
                        mPhase = 2; mSum = pendSum; mCout = pendCout; mValid = 1'b1;
                    end
                end
                default: if (out_ready) begin
                    mValid = 1'b0; mPhase = 0;
                end
            endcase
        end
    end

    // During an add only the finished low slices are visible; the rest was cleared on accept.
    always @(negedge clk) begin
        if (checkEn) begin
            expSum = (mPhase == 1) ? (pendSum & W'((64'd1 << (N * mCnt)) - 64'd1)) : mSum;
            checkOutput("in_ready", 64'(in_ready), 64'((mPhase == 0) && !rst));
            checkOutput("busy", 64'(busy), 64'(mPhase != 0));
            checkOutput("out_valid", 64'(out_valid), 64'(mValid));
            checkOutput("sum", 64'(sum), 64'(expSum));
            checkOutput("cout", 64'(cout), 64'(mCout));
        end
    end

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                 input logic s, input logic [W-1:0] expS, input logic expC,
                                 input int hold, input string name);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #2; t++;
        end
        if (t == 50) checkOutput({name, "_ready_timeout"}, 64'd0, 64'd1);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #2; lat++;
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'(WORDS));
        checkOutput({name, "_model"}, 64'({pendCout, pendSum}), 64'({expC, expS}));
        checkOutput({name, "_sum"}, 64'(sum), 64'(expS));
        checkOutput({name, "_cout"}, 64'(cout), 64'(expC));
        repeat (hold) begin
            in_valid = 1'($urandom);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            checkOutput({name, "_held_sum"}, 64'(sum), 64'(expS));
            checkOutput({name, "_held_cout"}, 64'(cout), 64'(expC));
            checkOutput({name, "_held_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_sum", 64'(sum), 64'd0);
        checkOutput("reset_cout", 64'(cout), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkEn = 1'b1;
        rst = 1'b0;
        @(posedge clk); #2;
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);

        applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 0, "wrap");
        applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, 32'h1, 1'b0, 0, "cin");
        applyStimulus(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 0, "ripple");
        applyStimulus(32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 0, "sub_borrow");
        applyStimulus(32'h7, 32'h5, 1'b1, 1'b1, 32'h2, 1'b1, 10, "sub_hold");

        // Abort during the second slice cycle, then confirm a clean follow-up op.
        a = 32'h1122_3344; b = 32'h0101_0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(posedge clk); #2;
        checkOutput("partial_sum", 64'(sum), 64'h45);
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_sum", 64'(sum), 64'd0);
        checkOutput("abort_cout", 64'(cout), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #2;
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 0, "after_abort");

        cyc = 0;
        mAccepts = 0;
        while (mAccepts < 1000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            a   = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            b   = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? '1 : '0) : W'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            @(posedge clk); #2;
            cyc++;
        end
        if (cyc >= 60000) checkOutput("random_ops_timeout", 64'(mAccepts), 64'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (WORDS + 3) @(posedge clk);
        #2;
        checkOutput("drain_idle", 64'(in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
